// File: rtl/sys_pll_rst_ctrl.sv
// Reset sequencer and lock supervisor for the system PLL.
// Pulses PLL reset, waits for and qualifies lock, then releases the system reset.
module sys_pll_rst_ctrl #(
  parameter int PLL_RST_CYCLES = 50,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             soft_reset,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_RT  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_RT > LOCK_STABLE) ? MAX_RT : LOCK_STABLE;
  localparam int CYC_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(LOCK_STABLE - 1);

  localparam logic [1:0] ST_RESET_PLL = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic [1:0]       lk_sync_reg;
  logic             lk_s;
  logic [1:0]       state_reg, state_next;
  logic [CYC_W-1:0] cyc_reg, cyc_next;
  logic             timeout_inc, loss_inc;
  logic [CNT_W-1:0] timeout_cnt_reg, timeout_cnt_next;
  logic [CNT_W-1:0] lock_loss_cnt_reg, lock_loss_cnt_next;
  logic             pll_rst_reg, sys_rst_reg, ready_reg;

  // pll_locked comes from the PLL's own domain; only the second stage is trusted.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_sync_reg <= 2'b00;
    end else begin
      lk_sync_reg <= {lk_sync_reg[0], pll_locked};
    end
  end

  assign lk_s = lk_sync_reg[1];

  always_comb begin
    state_next  = state_reg;
    cyc_next    = cyc_reg;
    timeout_inc = 1'b0;
    loss_inc    = 1'b0;
    case (state_reg)
      ST_RESET_PLL: begin
        if (soft_reset) begin
          cyc_next = '0;
        end else if (cyc_reg == RST_LAST) begin
          state_next = ST_WAIT_LOCK;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (soft_reset) begin
          state_next = ST_RESET_PLL;
        end else if (lk_s) begin
          state_next = ST_STABLE;
        end else if (cyc_reg == TIMEOUT_LAST) begin
          state_next  = ST_RESET_PLL;
          timeout_inc = 1'b1;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      ST_STABLE: begin
        if (soft_reset) begin
          state_next = ST_RESET_PLL;
        end else if (!lk_s) begin
          state_next = ST_WAIT_LOCK;
        end else if (cyc_reg == STABLE_LAST) begin
          state_next = ST_RUN;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (soft_reset) begin
          state_next = ST_RESET_PLL;
        end else if (!lk_s) begin
          state_next = ST_RESET_PLL;
          loss_inc   = 1'b1;
        end
      end
      default: begin
        state_next = ST_RESET_PLL;
      end
    endcase
    // Every state entry starts a fresh count window.
    if (state_next != state_reg) begin
      cyc_next = '0;
    end
  end

  always_comb begin
    timeout_cnt_next   = timeout_cnt_reg;
    lock_loss_cnt_next = lock_loss_cnt_reg;
    if (timeout_inc && (timeout_cnt_reg != {CNT_W{1'b1}})) begin
      timeout_cnt_next = timeout_cnt_reg + 1'b1;
    end
    if (loss_inc && (lock_loss_cnt_reg != {CNT_W{1'b1}})) begin
      lock_loss_cnt_next = lock_loss_cnt_reg + 1'b1;
    end
  end

  // Outputs decode the next state so they change on the same edge as the state itself.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_RESET_PLL;
      cyc_reg           <= '0;
      timeout_cnt_reg   <= '0;
      lock_loss_cnt_reg <= '0;
      pll_rst_reg       <= 1'b1;
      sys_rst_reg       <= 1'b1;
      ready_reg         <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cyc_reg           <= cyc_next;
      timeout_cnt_reg   <= timeout_cnt_next;
      lock_loss_cnt_reg <= lock_loss_cnt_next;
      pll_rst_reg       <= (state_next == ST_RESET_PLL);
      sys_rst_reg       <= (state_next != ST_RUN);
      ready_reg         <= (state_next == ST_RUN);
    end
  end

  assign pll_rst       = pll_rst_reg;
  assign sys_rst       = sys_rst_reg;
  assign ready         = ready_reg;
  assign timeout_cnt   = timeout_cnt_reg;
  assign lock_loss_cnt = lock_loss_cnt_reg;

endmodule

// File: tb/tb_sys_pll_rst_ctrl.sv
// Directed bench for sys_pll_rst_ctrl with small sequencing parameters.
// Inputs are driven and outputs sampled on the falling edge of refclk.
module tb_sys_pll_rst_ctrl;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 20;
  localparam int LOCK_STABLE    = 8;
  localparam int CNT_W          = 3;

  // pll_locked raised on a falling edge: 2 sync edges, 1 edge into STABLE, 8 STABLE cycles.
  localparam int LOCK_TO_READY  = 2 + 1 + LOCK_STABLE;

  logic             refclk;
  logic             rst;
  logic             pll_locked;
  logic             soft_reset;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [CNT_W-1:0] timeout_cnt;
  logic [CNT_W-1:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;
  int n;

  sys_pll_rst_ctrl #(
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .LOCK_STABLE   (LOCK_STABLE),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .soft_reset   (soft_reset),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .timeout_cnt  (timeout_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return ready;
      default: return sys_rst;
    endcase
  endfunction

  // Counts falling edges until the selected output equals val, bounded by limit.
  task automatic wait_until(input int sel, input logic val, input int limit, output int cnt);
    cnt = 0;
    while ((sig_of(sel) !== val) && (cnt < limit)) begin
      @(negedge refclk);
      cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge refclk);
    rst        = 1'b1;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    repeat (3) @(negedge refclk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    soft_reset = 1'b0;

    // 1: normal bring-up
    do_reset();
    check_val("t1 reset pll_rst", pll_rst, 1);
    check_val("t1 reset sys_rst", sys_rst, 1);
    check_val("t1 reset ready", ready, 0);
    check_val("t1 reset timeout_cnt", timeout_cnt, 0);
    check_val("t1 reset lock_loss_cnt", lock_loss_cnt, 0);
    wait_until(0, 1'b0, 50, n);
    check_val("t1 pll_rst width", n, PLL_RST_CYCLES);
    repeat (6) @(negedge refclk);
    pll_locked = 1'b1;
    wait_until(1, 1'b1, 100, n);
    check_val("t1 lock to ready", n, LOCK_TO_READY);
    check_val("t1 run sys_rst", sys_rst, 0);
    check_val("t1 run pll_rst", pll_rst, 0);
    check_val("t1 timeout_cnt", timeout_cnt, 0);
    check_val("t1 lock_loss_cnt", lock_loss_cnt, 0);

    // 2: no lock, repeated timeouts with saturation
    do_reset();
    wait_until(0, 1'b0, 50, n);
    check_val("t2 first pll_rst width", n, PLL_RST_CYCLES);
    for (int k = 1; k <= 9; k++) begin
      wait_until(0, 1'b1, 100, n);
      check_val($sformatf("t2 wait window %0d", k), n, LOCK_TIMEOUT);
      check_val($sformatf("t2 timeout_cnt %0d", k), timeout_cnt, (k > 7) ? 7 : k);
      wait_until(0, 1'b0, 50, n);
      check_val($sformatf("t2 repulse width %0d", k), n, PLL_RST_CYCLES);
    end
    check_val("t2 lock_loss_cnt", lock_loss_cnt, 0);

    // 3: lock glitch while qualifying (drop seen by the FSM at stable count 5)
    do_reset();
    repeat (10) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (6) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    check_val("t3 glitch ready", ready, 0);
    check_val("t3 glitch sys_rst", sys_rst, 1);
    check_val("t3 glitch pll_rst", pll_rst, 0);
    pll_locked = 1'b1;
    wait_until(1, 1'b1, 100, n);
    check_val("t3 relock to ready", n, LOCK_TO_READY);
    check_val("t3 timeout_cnt", timeout_cnt, 0);
    check_val("t3 lock_loss_cnt", lock_loss_cnt, 0);

    // 4: lock loss in RUN
    repeat (2) @(negedge refclk);
    pll_locked = 1'b0;
    wait_until(1, 1'b0, 10, n);
    check_val("t4 loss latency", n, 3);
    check_val("t4 sys_rst", sys_rst, 1);
    check_val("t4 pll_rst", pll_rst, 1);
    check_val("t4 lock_loss_cnt", lock_loss_cnt, 1);
    wait_until(0, 1'b0, 20, n);
    check_val("t4 pll_rst width", n, PLL_RST_CYCLES);
    pll_locked = 1'b1;
    wait_until(1, 1'b1, 100, n);
    check_val("t4 relock to ready", n, LOCK_TO_READY);
    check_val("t4 timeout_cnt", timeout_cnt, 0);

    // 5: soft_reset held in RUN, then soft_reset coinciding with a lock drop
    repeat (2) @(negedge refclk);
    soft_reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge refclk);
      check_val($sformatf("t5 held pll_rst %0d", i), pll_rst, 1);
    end
    soft_reset = 1'b0;
    wait_until(0, 1'b0, 20, n);
    check_val("t5 pll_rst after release", n, PLL_RST_CYCLES);
    check_val("t5 lock_loss_cnt", lock_loss_cnt, 1);
    wait_until(1, 1'b1, 100, n);
    check_val("t5 back to ready", n, 1 + LOCK_STABLE);
    repeat (2) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    soft_reset = 1'b1;
    @(negedge refclk);
    soft_reset = 1'b0;
    check_val("t5 simul ready", ready, 0);
    check_val("t5 simul pll_rst", pll_rst, 1);
    check_val("t5 simul lock_loss_cnt", lock_loss_cnt, 1);
    repeat (6) @(negedge refclk);
    check_val("t5 simul lock_loss_cnt later", lock_loss_cnt, 1);

    // 6: asynchronous rst mid-RUN and mid-WAIT_LOCK
    pll_locked = 1'b1;
    wait_until(1, 1'b1, 100, n);
    check_val("t6 run reached", ready, 1);
    check_val("t6 lock_loss_cnt before rst", lock_loss_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check_val("t6 run async pll_rst", pll_rst, 1);
    check_val("t6 run async sys_rst", sys_rst, 1);
    check_val("t6 run async ready", ready, 0);
    @(negedge refclk);
    rst        = 1'b0;
    pll_locked = 1'b0;
    check_val("t6 run lock_loss_cnt after", lock_loss_cnt, 0);
    check_val("t6 run timeout_cnt after", timeout_cnt, 0);
    repeat (30) @(negedge refclk);
    check_val("t6 wait timeout_cnt before", timeout_cnt, 1);
    check_val("t6 wait pll_rst before", pll_rst, 0);
    check_val("t6 wait sys_rst before", sys_rst, 1);
    #2 rst = 1'b1;
    #1;
    check_val("t6 wait async pll_rst", pll_rst, 1);
    check_val("t6 wait async sys_rst", sys_rst, 1);
    check_val("t6 wait async ready", ready, 0);
    @(negedge refclk);
    rst = 1'b0;
    check_val("t6 wait timeout_cnt after", timeout_cnt, 0);
    wait_until(0, 1'b0, 50, n);
    check_val("t6 restart pll_rst width", n, PLL_RST_CYCLES);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
